// File: rtl/sr_iter.sv
//------------------------------------------------------------------------------
// Module : sr_iter
// Multi-cycle iterative right shifter. It shifts by up to STEP bit positions
// per clock until the captured shift amount is used up. It talks to the
// controller FSM through a start/busy/done handshake.
// Revision: 1.0 - initial release
//
// Ports:
//   clk      in   1        rising-edge clock
//   reset_n  in   1        asynchronous active-low reset
//   start    in   1        request; sampled when not busy (IDLE or DONE)
//   a        in   WIDTH    operand, captured on an accepted start
//   shamt    in   SHAMT_W  shift amount, captured on an accepted start
//   arith    in   1        1 = sign fill, 0 = zero fill
//   rot      in   1        rotate right (only with SR_ROTATE_EN)
//   busy     out  1        high while shifting
//   done     out  1        one-cycle pulse; y is valid in this cycle
//   y        out  WIDTH    result, held until the next accepted start
//
// Build option: define SR_ROTATE_EN to add rotate-right support.
//------------------------------------------------------------------------------
`default_nettype none

module sr_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  input  logic               rot,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   y
);

  localparam logic [SHAMT_W-1:0] C_STEP = SHAMT_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               arith_q, arith_d;
  logic [SHAMT_W-1:0] w_k;
  logic [WIDTH-1:0]   w_shifted;

`ifdef SR_ROTATE_EN
  logic rot_q, rot_d;
`else
  logic unused_rot;
  assign unused_rot = rot;
`endif

  // Step size for this cycle: whatever is left, capped at STEP.
  assign w_k = (rem_q < C_STEP) ? rem_q : C_STEP;

  // Only the STEP constant shift distances exist in hardware; w_k selects
  // one of them, so no full barrel shifter is built.
  always_comb begin
    w_shifted = y_q;
    for (int i = 1; i <= STEP; i++) begin
      if (w_k == SHAMT_W'(i)) begin
        if (arith_q) begin
          w_shifted = $signed(y_q) >>> i;
        end else begin
          w_shifted = y_q >> i;
        end
`ifdef SR_ROTATE_EN
        // Rotate takes priority over the arithmetic fill.
        if (rot_q) begin
          w_shifted = (y_q >> i) | (y_q << (WIDTH - i));
        end
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    rem_d   = rem_q;
    arith_d = arith_q;
`ifdef SR_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      // DONE accepts a new start just like IDLE, so operations can run
      // back to back.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          y_d     = a;
          rem_d   = shamt;
          arith_d = arith;
`ifdef SR_ROTATE_EN
          rot_d   = rot;
`endif
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        y_d   = w_shifted;
        rem_d = rem_q - w_k;
        if (rem_q == w_k) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      rem_q   <= '0;
      arith_q <= 1'b0;
`ifdef SR_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      arith_q <= arith_d;
`ifdef SR_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // Outputs come straight from flops, so there is no input-to-output path.
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign y    = y_q;

endmodule

`default_nettype wire
